// File: rtl/rgb_blink.sv
// RGB breathing generator: prescaled counter drives three
// 120-degree-offset triangle duties, one registered PWM bit per colour.
module rgb_blink #(
  parameter int COUNTER_BITS = 16,
  parameter int PRESCALER    = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic pwm_red,
  output logic pwm_blue,
  output logic pwm_green
);

  logic                    tick;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]              pwm_cnt, phase;
  logic [7:0]              p_r, p_g, p_b;
  logic                    red_q, red_d;
  logic                    grn_q, grn_d;
  logic                    blu_q, blu_d;

  function automatic logic [7:0] tri_wave(input logic [7:0] p);
    return p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
  endfunction

  generate
    if (PRESCALER == 0) begin : g_nopre
      assign tick = 1'b1;
    end else begin : g_pre
      logic [PRESCALER-1:0] pre_q, pre_d;
      assign pre_d = pre_q + PRESCALER'(1);
      assign tick  = &pre_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
      end
    end
  endgenerate

  assign cnt_d   = tick ? cnt_q + COUNTER_BITS'(1) : cnt_q;
  assign pwm_cnt = cnt_q[7:0];
  assign phase   = cnt_q[COUNTER_BITS-1 -: 8];
  assign p_r     = phase;
  assign p_g     = phase + 8'd85;
  assign p_b     = phase + 8'd170;

  // Duty is compared live every clock; no per-period latching.
  always_comb begin
    red_d = pwm_cnt < tri_wave(p_r);
    grn_d = pwm_cnt < tri_wave(p_g);
    blu_d = pwm_cnt < tri_wave(p_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      red_q <= 1'b0;
      grn_q <= 1'b0;
      blu_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign pwm_red   = red_q;
  assign pwm_green = grn_q;
  assign pwm_blue  = blu_q;

endmodule

// File: tb/tb_rgb_blink.sv
// Bench for rgb_blink: a fast (no prescale) and a default instance
// checked against an arithmetic model plus a table of known points.
module tb_rgb_blink;

  logic clk;
  logic rst_n;
  logic f_r, f_g, f_b;
  logic s_r, s_g, s_b;

  int total;
  int bad;
  int n;
  bit chk_en;

  rgb_blink #(.COUNTER_BITS(16), .PRESCALER(0)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .pwm_red(f_r), .pwm_blue(f_b), .pwm_green(f_g)
  );

  rgb_blink #(.COUNTER_BITS(16), .PRESCALER(3)) u_slow (
    .clk(clk), .rst_n(rst_n),
    .pwm_red(s_r), .pwm_blue(s_b), .pwm_green(s_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int trw(int p);
    return (p < 128) ? 2 * p : 2 * (255 - p);
  endfunction

  // Expected {r,g,b} after n clock edges since reset release.
  function automatic logic [2:0] model(int edges, int pre);
    int c, pc, ph;
    logic [2:0] v;
    if (edges <= 0) return 3'b000;
    c  = ((edges - 1) >> pre) & 16'hFFFF;
    pc = c & 255;
    ph = (c >> 8) & 255;
    v[2] = pc < trw(ph);
    v[1] = pc < trw((ph + 85) % 256);
    v[0] = pc < trw((ph + 170) % 256);
    return v;
  endfunction

  task automatic check(string nm, logic [2:0] act, logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got rgb=%b want rgb=%b", nm, n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_fast", {f_r, f_g, f_b}, model(n, 0));
      check("model_slow", {s_r, s_g, s_b}, model(n, 3));
    end
  end

  typedef struct {
    int   en;
    bit   slow;
    logic [2:0] rgb;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1,     1'b0, 3'b011};
    tbl[1]  = '{170,   1'b0, 3'b011};
    tbl[2]  = '{171,   1'b0, 3'b000};
    tbl[3]  = '{257,   1'b0, 3'b111};
    tbl[4]  = '{258,   1'b0, 3'b111};
    tbl[5]  = '{259,   1'b0, 3'b011};
    tbl[6]  = '{1360,  1'b1, 3'b011};
    tbl[7]  = '{1361,  1'b1, 3'b000};
    tbl[8]  = '{32513, 1'b0, 3'b111};
    tbl[9]  = '{32766, 1'b0, 3'b100};
    tbl[10] = '{32767, 1'b0, 3'b000};
    tbl[11] = '{65536, 1'b0, 3'b000};
    tbl[12] = '{65537, 1'b0, 3'b011};

    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_fast", {f_r, f_g, f_b}, 3'b000);
    check("reset_slow", {s_r, s_g, s_b}, 3'b000);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      while (n < tbl[i].en) begin
        @(posedge clk);
        #2;
      end
      if (tbl[i].slow)
        check($sformatf("tbl%0d_slow", i), {s_r, s_g, s_b}, tbl[i].rgb);
      else
        check($sformatf("tbl%0d_fast", i), {f_r, f_g, f_b}, tbl[i].rgb);
    end

    // Asynchronous reset at random points mid-run.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(50, 3000)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check("async_rst_fast", {f_r, f_g, f_b}, 3'b000);
      check("async_rst_slow", {s_r, s_g, s_b}, 3'b000);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end

    repeat (300) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
